// File: rtl/msk_inv_pipe_pkg.sv
// rtl/msk_inv_pipe_pkg.sv - shared masking-gadget constants
package msk_inv_pipe_pkg;
  localparam int DEFAULTSHARES = 2;
  localparam int LATENCY_MAX   = 8;
endpackage

// File: rtl/msk_share_stage.sv
// rtl/msk_share_stage.sv - one elastic register stage holding final output shares
module msk_share_stage #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] up_data,
  input  logic         up_valid,
  output logic         up_ready,
  output logic [W-1:0] dn_data,
  output logic         dn_valid,
  input  logic         dn_ready
);
  // An empty stage always accepts, so bubbles collapse toward the output.
  assign up_ready = !dn_valid || dn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) dn_data <= up_data;
    end
  end
endmodule

// File: rtl/msk_inv_pipe.sv
// rtl/msk_inv_pipe.sv - masked inversion of share 0 followed by an elastic pipeline
module msk_inv_pipe
  import msk_inv_pipe_pkg::*;
#(
  parameter int               d       = DEFAULTSHARES,
  parameter int               count   = 1,
  parameter int               LATENCY = 1,
  parameter logic [count-1:0] CONST   = '1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [count*d-1:0] in,
  input  logic [count-1:0]   inv_en,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [count*d-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
);
  localparam int W = count * d;

  logic [W-1:0] xored;

  // Only share 0 is touched; shares of one channel never meet.
  for (genvar i = 0; i < count; i++) begin : g_ch
    assign xored[i*d] = in[i*d] ^ (CONST[i] & inv_en[i]);
    if (d > 1) begin : g_pass
      assign xored[i*d+1 +: d-1] = in[i*d+1 +: d-1];
    end
  end

  if (LATENCY == 0) begin : g_comb
    assign out       = xored;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;
  end else begin : g_pipe
    logic [W-1:0] sd [LATENCY+1];
    logic         sv [LATENCY+1];
    logic         sr [LATENCY+1];

    assign sd[0]       = xored;
    assign sv[0]       = in_valid;
    assign sr[LATENCY] = out_ready;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      msk_share_stage #(.W(W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .up_data (sd[k]),
        .up_valid(sv[k]),
        .up_ready(sr[k]),
        .dn_data (sd[k+1]),
        .dn_valid(sv[k+1]),
        .dn_ready(sr[k+1])
      );
    end

    assign in_ready  = sr[0];
    assign out       = sd[LATENCY];
    assign out_valid = sv[LATENCY];
  end
endmodule

// File: tb/tb_msk_inv_pipe.sv
// tb/tb_msk_inv_pipe.sv - self-checking bench for msk_inv_pipe
module tb_msk_inv_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // share 0 of channel i flips when inv_en[i] is set (CONST all ones)
  function automatic logic [31:0] apply_inv(input logic [31:0] x, input logic [7:0] inv,
                                            input int dd, input int cnt);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < cnt; i++) r[i*dd] = r[i*dd] ^ inv[i];
    return r;
  endfunction

  function automatic logic [7:0] unmask(input logic [31:0] x, input int dd, input int cnt);
    logic [7:0] u;
    u = '0;
    for (int i = 0; i < cnt; i++)
      for (int s = 0; s < dd; s++) u[i] = u[i] ^ x[i*dd+s];
    return u;
  endfunction

  // instance A: d=2, count=2, L=2
  logic       rst_a = 1'b0, iv_a = 1'b0, ir_a, ov_a, or_a = 1'b1;
  logic [3:0] in_a = '0, out_a;
  logic [1:0] inv_a = '0;
  msk_inv_pipe #(.d(2), .count(2), .LATENCY(2)) u_a (
    .clk(clk), .rst_n(rst_a), .in(in_a), .inv_en(inv_a), .in_valid(iv_a),
    .in_ready(ir_a), .out(out_a), .out_valid(ov_a), .out_ready(or_a));

  // instance B: d=3, count=1, L=0, CONST=1
  logic       rst_b = 1'b1, iv_b = 1'b0, ir_b, ov_b, or_b = 1'b0, inv_b = 1'b0;
  logic [2:0] in_b = '0, out_b;
  msk_inv_pipe #(.d(3), .count(1), .LATENCY(0), .CONST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_b), .in(in_b), .inv_en(inv_b), .in_valid(iv_b),
    .in_ready(ir_b), .out(out_b), .out_valid(ov_b), .out_ready(or_b));

  // instance C: d=4, count=8, L=3
  logic        rst_c = 1'b0, iv_c = 1'b0, ir_c, ov_c, or_c = 1'b0;
  logic [31:0] in_c = '0, out_c;
  logic [7:0]  inv_c = '0;
  msk_inv_pipe #(.d(4), .count(8), .LATENCY(3)) u_c (
    .clk(clk), .rst_n(rst_c), .in(in_c), .inv_en(inv_c), .in_valid(iv_c),
    .in_ready(ir_c), .out(out_c), .out_valid(ov_c), .out_ready(or_c));

  // scoreboards, updated between edges
  logic [31:0] q_a[$];
  int          acc_a = 0, del_a = 0;
  always @(negedge clk) begin
    if (!rst_a) q_a.delete();
    else begin
      if (ov_a && or_a) begin
        check("a_beat_expected", q_a.size() != 0, 1);
        if (q_a.size() != 0) check("a_order", {28'b0, out_a}, q_a.pop_front());
        del_a++;
      end
      if (iv_a && ir_a) begin
        q_a.push_back(apply_inv({28'b0, in_a}, {6'b0, inv_a}, 2, 2));
        acc_a++;
      end
    end
  end

  logic [31:0] q_c_sh[$];
  logic [7:0]  q_c_u[$];
  int          acc_c = 0, del_c = 0;
  logic        stall_c = 1'b0;
  logic [31:0] held_c = '0;
  always @(negedge clk) begin
    if (!rst_c) begin
      q_c_sh.delete(); q_c_u.delete(); stall_c = 1'b0;
    end else begin
      if (stall_c) check("c_hold_stable", out_c, held_c);
      if (ov_c && or_c) begin
        check("c_beat_expected", q_c_sh.size() != 0, 1);
        if (q_c_sh.size() != 0) begin
          check("c_unmasked", unmask(out_c, 4, 8), q_c_u.pop_front());
          check("c_shares", out_c, q_c_sh.pop_front());
        end
        del_c++;
      end
      if (iv_c && ir_c) begin
        q_c_u.push_back(unmask(in_c, 4, 8) ^ inv_c);
        q_c_sh.push_back(apply_inv(in_c, inv_c, 4, 8));
        acc_c++;
      end
      stall_c = ov_c && !or_c;
      held_c  = out_c;
    end
  end

  task automatic run_a();
    logic [3:0] beats[8];
    int j, a0, d0;
    repeat (2) @(posedge clk);
    #1;
    check("a_rst_out_valid", ov_a, 0);
    check("a_rst_out", out_a, 0);
    check("a_rst_in_ready", ir_a, 1);
    rst_a = 1'b1;
    @(posedge clk); #1;
    in_a = 4'b0110; inv_a = 2'b11; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    check("a_lat_c1_valid", ov_a, 0);
    @(posedge clk); #1;
    check("a_lat_c2_valid", ov_a, 1);
    check("a_lat_c2_out", out_a, 4'b0011);
    @(posedge clk); #1;
    check("a_lat_c3_valid", ov_a, 0);
    // back-to-back beats without inversion
    inv_a = 2'b00;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin beats[k] = 4'($urandom); in_a = beats[k]; iv_a = 1'b1; end
      else iv_a = 1'b0;
      #1;
      check("a_b2b_valid", ov_a, k >= 2);
      check("a_b2b_in_ready", ir_a, 1);
      if (k >= 2) check("a_b2b_out", out_a, beats[k-2]);
      @(posedge clk); #1;
    end
    // stall with continuous input
    a0 = acc_a; d0 = del_a; j = 0;
    for (int c = 0; c < 40 && j < 6; c++) begin
      or_a = (c >= 5);
      in_a = beats[j]; iv_a = 1'b1;
      #1;
      if (c >= 2 && c < 5) begin
        check("a_full_in_ready", ir_a, 0);
        check("a_stall_valid", ov_a, 1);
        check("a_stall_out", out_a, beats[0]);
      end
      if (ir_a) j++;
      @(posedge clk); #1;
    end
    iv_a = 1'b0; or_a = 1'b1;
    for (int c = 0; c < 20 && q_a.size() != 0; c++) @(posedge clk);
    #1;
    check("a_drain_empty", q_a.size(), 0);
    check("a_accepted", acc_a - a0, 6);
    check("a_delivered", del_a - d0, acc_a - a0);
    // reset with two beats in flight
    or_a = 1'b0; iv_a = 1'b1; in_a = 4'b1010;
    @(posedge clk); #1;
    in_a = 4'b0101;
    @(posedge clk); #1;
    iv_a = 1'b0;
    check("a_pre_rst_valid", ov_a, 1);
    #2 rst_a = 1'b0;
    #1;
    check("a_mid_rst_valid", ov_a, 0);
    check("a_mid_rst_out", out_a, 0);
    check("a_mid_rst_in_ready", ir_a, 1);
    @(posedge clk); #1;
    rst_a = 1'b1; or_a = 1'b1;
    check("a_post_rst_in_ready", ir_a, 1);
    in_a = 4'b1001; inv_a = 2'b01; iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0;
    check("a_post_rst_c1_valid", ov_a, 0);
    @(posedge clk); #1;
    check("a_post_rst_c2_valid", ov_a, 1);
    check("a_post_rst_c2_out", out_a, 4'b1000);
    @(posedge clk); #1;
    check("a_post_rst_c3_valid", ov_a, 0);
  endtask

  task automatic run_b();
    #3;
    in_b = 3'b101; inv_b = 1'b1; iv_b = 1'b1; or_b = 1'b1;
    #1;
    check("b_out", out_b, 3'b100);
    check("b_out_valid", ov_b, 1);
    check("b_in_ready_hi", ir_b, 1);
    or_b = 1'b0;
    #1;
    check("b_in_ready_lo", ir_b, 0);
    for (int k = 0; k < 8; k++) begin
      in_b = 3'($urandom); inv_b = 1'($urandom); iv_b = 1'($urandom); or_b = 1'($urandom);
      #1;
      check("b_rand_out", {29'b0, out_b}, apply_inv({29'b0, in_b}, {7'b0, inv_b}, 3, 1));
      check("b_rand_valid", ov_b, iv_b);
      check("b_rand_ready", ir_b, or_b);
    end
  endtask

  task automatic run_c();
    repeat (2) @(posedge clk);
    #1;
    check("c_rst_out", out_c, 0);
    check("c_rst_in_ready", ir_c, 1);
    rst_c = 1'b1;
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      iv_c  = ($urandom_range(0, 3) != 0);
      or_c  = ($urandom_range(0, 3) != 0);
      in_c  = $urandom;
      inv_c = 8'($urandom);
    end
    @(posedge clk); #1;
    iv_c = 1'b0; or_c = 1'b1;
    for (int c = 0; c < 20 && q_c_sh.size() != 0; c++) @(posedge clk);
    #1;
    check("c_drain_empty", q_c_sh.size(), 0);
    check("c_delivered", del_c, acc_c);
  endtask

  initial begin
    fork
      run_a();
      run_b();
      run_c();
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
